bw_bbox_scan: RTL and testbench
===============================

BW_BBOX_SCAN -- requirements
Module: bw_bbox_scan

Interface
REQ-001 The block SHALL have parameter IMG_W, default 320, image width in pixels.
REQ-002 The block SHALL have parameter IMG_H, default 240, image height in pixels.
REQ-003 Port clk, input, 1: the single clock; all state SHALL change on its rising edge.
REQ-004 Port rst, input, 1: reset; it SHALL be synchronous and active-high.
REQ-005 Port start, input, 1: scan request, level, held by the controlling FSM.
REQ-006 Port ack, input, 1: result acknowledge from the controlling FSM.
REQ-007 Port done, output, 1: result valid and held.
REQ-008 Port rd_addr, output, 17: read address to the 1-bit black/white frame memory, equal to y*IMG_W+x.
REQ-009 Port rd_data, input, 1: memory data; it SHALL be valid exactly 1 clk after rd_addr is presented.
REQ-010 Port found, output, 1: at least one set pixel was seen in the last scan.
REQ-011 Ports x_min, x_max, y_min, y_max, output, 9 each: bounding box of set pixels.

Function
REQ-012 The state machine SHALL have the states IDLE, SCAN, DRAIN and DONE.
REQ-013 In IDLE with start=1, the block SHALL clear the accumulators, set x=y=0, and enter SCAN on the next edge.
REQ-014 In SCAN, the block SHALL present one address per cycle, in raster order from 0 to IMG_W*IMG_H-1.
- x SHALL wrap to 0 at IMG_W-1 and y SHALL increment at that point.
REQ-015 The block SHALL delay x and y by 1 cycle to align them with rd_data.
- When rd_data=1: x_min/y_min SHALL take min(current, x/y) and x_max/y_max SHALL take max(current, x/y).
- The first set pixel SHALL load all four values directly.
REQ-016 After the last address, the block SHALL enter DRAIN for 1 cycle so the final pixel is accumulated, then enter DONE.
REQ-017 The output registers SHALL load at the DRAIN->DONE edge only; they SHALL stay stable during SCAN and DRAIN.
REQ-018 If start is sampled at cycle 0, done SHALL go high in cycle IMG_W*IMG_H+2.
REQ-019 done SHALL be 1 only in DONE, and SHALL remain 1 until ack=1 is sampled; the block SHALL then return to IDLE with done=0 on the next cycle.
REQ-020 start SHALL be ignored in SCAN, DRAIN and DONE.
- ack SHALL be ignored outside DONE.
- If start and ack are both high in DONE, ack SHALL win; start is re-sampled in IDLE on the following cycle.
REQ-021 If no set pixel is seen, the block SHALL output found=0 and x_min=x_max=y_min=y_max=0.
REQ-022 rd_addr SHALL be 0 in IDLE and DONE, and SHALL be 17 bits wide, zero-extended.

Reset
REQ-023 When rst=1, the block SHALL enter IDLE on the next edge, regardless of state, including mid-scan.
REQ-024 Reset values SHALL be: done=0, found=0, all bounding-box outputs 0, rd_addr=0, counters 0.
REQ-025 A partially accumulated box SHALL be discarded on reset; it SHALL never be output.

Configuration
REQ-026 With macro BW_BBOX_PIXEL_COUNT_EN defined, the block SHALL add output port pixel_count, 17 bits.
- pixel_count SHALL hold the number of set pixels in the last scan.
- It SHALL load at the same edge as the box, and reset to 0.
REQ-027 Without BW_BBOX_PIXEL_COUNT_EN, the port and the counter SHALL be absent; all other behaviour SHALL be identical.

Verification (IMG_W=8, IMG_H=4, 1-cycle memory model)
REQ-028 All-zero image, start held -> done=1 at cycle 34; found=0; box all 0; pixel_count=0.
REQ-029 Single set pixel at addr 21 -> x_min=x_max=5, y_min=y_max=2, found=1, pixel_count=1.
REQ-030 Set pixels at (1,3) and (6,0), i.e. addr 25 and 6 -> x_min=1, x_max=6, y_min=0, y_max=3, pixel_count=2.
REQ-031 All-ones image -> x_min=0, x_max=7, y_min=0, y_max=3, pixel_count=32; a second scan of a single pixel at addr 0 -> box 0,0,0,0, proving the accumulators are cleared.
REQ-032 rst pulsed at cycle 10 of SCAN -> next cycle done=0, outputs 0, rd_addr=0; a new start then yields a correct box at cycle 34 after that start.
REQ-033 In DONE, hold ack=0 for 100 cycles while toggling start -> done stays 1 and outputs stay stable; ack=1 with start=1 -> done=0 next cycle, then a new scan begins.

Source files
------------

// File: rtl/bw_bbox_scan_if.sv
// Frame-scan handshake and result bundle for bw_bbox_scan.
// pixel_count exists only with BW_BBOX_PIXEL_COUNT_EN.
interface bw_bbox_scan_if;
  logic        start;
  logic        ack;
  logic        done;
  logic [16:0] rd_addr;
  logic        rd_data;
  logic        found;
  logic [8:0]  x_min;
  logic [8:0]  x_max;
  logic [8:0]  y_min;
  logic [8:0]  y_max;
`ifdef BW_BBOX_PIXEL_COUNT_EN
  logic [16:0] pixel_count;
`endif

  modport master (
    output start, ack, rd_data,
    input  done, rd_addr, found,
    input  x_min, x_max, y_min, y_max
`ifdef BW_BBOX_PIXEL_COUNT_EN
    , input pixel_count
`endif
  );

  modport slave (
    input  start, ack, rd_data,
    output done, rd_addr, found,
    output x_min, x_max, y_min, y_max
`ifdef BW_BBOX_PIXEL_COUNT_EN
    , output pixel_count
`endif
  );
endinterface

// File: rtl/bw_bbox_scan.sv
// Raster scan of a 1-bit frame memory producing the set-pixel bounding box.
// Optional set-pixel counter: define BW_BBOX_PIXEL_COUNT_EN.
module bw_bbox_scan #(
  parameter int IMG_W = 320,
  parameter int IMG_H = 240
) (
  input logic     clk,
  input logic     rst,
  bw_bbox_scan_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE, SCAN, DRAIN, DONE
  } state_t;

  localparam logic [16:0] LAST = 17'(IMG_W * IMG_H - 1);
  localparam logic [8:0]  XL   = 9'(IMG_W - 1);

  state_t      state;
  logic [8:0]  x, y, px, py;
  logic        pv;
  logic        a_found;
  logic [8:0]  a_xmin, a_xmax, a_ymin, a_ymax;
  logic        n_found;
  logic [8:0]  n_xmin, n_xmax, n_ymin, n_ymax;
  logic        hit;
`ifdef BW_BBOX_PIXEL_COUNT_EN
  logic [16:0] a_cnt, n_cnt;
`endif

  // px/py/pv trail the address by one cycle to line up with rd_data
  always_comb begin
    hit     = pv & bus.rd_data;
    n_found = a_found | hit;
    n_xmin  = a_xmin;
    n_xmax  = a_xmax;
    n_ymin  = a_ymin;
    n_ymax  = a_ymax;
    if (hit && !a_found) begin
      n_xmin = px;
      n_xmax = px;
      n_ymin = py;
      n_ymax = py;
    end else if (hit) begin
      if (px < a_xmin) n_xmin = px;
      if (px > a_xmax) n_xmax = px;
      if (py < a_ymin) n_ymin = py;
      if (py > a_ymax) n_ymax = py;
    end
`ifdef BW_BBOX_PIXEL_COUNT_EN
    n_cnt = a_cnt + {16'd0, hit};
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      x           <= '0;
      y           <= '0;
      px          <= '0;
      py          <= '0;
      pv          <= 1'b0;
      a_found     <= 1'b0;
      a_xmin      <= '0;
      a_xmax      <= '0;
      a_ymin      <= '0;
      a_ymax      <= '0;
      bus.done    <= 1'b0;
      bus.rd_addr <= '0;
      bus.found   <= 1'b0;
      bus.x_min   <= '0;
      bus.x_max   <= '0;
      bus.y_min   <= '0;
      bus.y_max   <= '0;
`ifdef BW_BBOX_PIXEL_COUNT_EN
      a_cnt           <= '0;
      bus.pixel_count <= '0;
`endif
    end else begin
      px <= x;
      py <= y;
      pv <= (state == SCAN);
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            a_found     <= 1'b0;
            a_xmin      <= '0;
            a_xmax      <= '0;
            a_ymin      <= '0;
            a_ymax      <= '0;
`ifdef BW_BBOX_PIXEL_COUNT_EN
            a_cnt       <= '0;
`endif
            x           <= '0;
            y           <= '0;
            bus.rd_addr <= '0;
            state       <= SCAN;
          end
        end
        SCAN: begin
          a_found <= n_found;
          a_xmin  <= n_xmin;
          a_xmax  <= n_xmax;
          a_ymin  <= n_ymin;
          a_ymax  <= n_ymax;
`ifdef BW_BBOX_PIXEL_COUNT_EN
          a_cnt   <= n_cnt;
`endif
          if (bus.rd_addr == LAST) begin
            x           <= '0;
            y           <= '0;
            bus.rd_addr <= '0;
            state       <= DRAIN;
          end else begin
            bus.rd_addr <= bus.rd_addr + 17'd1;
            if (x == XL) begin
              x <= '0;
              y <= y + 9'd1;
            end else begin
              x <= x + 9'd1;
            end
          end
        end
        DRAIN: begin
          // final pixel arrives now, so publish the combined value
          bus.found <= n_found;
          bus.x_min <= n_xmin;
          bus.x_max <= n_xmax;
          bus.y_min <= n_ymin;
          bus.y_max <= n_ymax;
`ifdef BW_BBOX_PIXEL_COUNT_EN
          bus.pixel_count <= n_cnt;
`endif
          bus.done  <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (bus.ack) begin
            bus.done <= 1'b0;
            state    <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bw_bbox_scan.sv
// Directed bench for bw_bbox_scan on an 8x4 image.
// Memory model returns data one cycle after the address.
module tb_bw_bbox_scan;
  logic clk;
  logic rst;
  logic mem [0:31];
  int   checks;
  int   errors;

  bw_bbox_scan_if bus ();

  bw_bbox_scan #(.IMG_W(8), .IMG_H(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_ff @(posedge clk) bus.rd_data <= mem[bus.rd_addr[4:0]];

  task automatic clear_img();
    for (int i = 0; i < 32; i++) mem[i] = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    for (int i = 1; i <= 200; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.done === 1'b1) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic run_scan(output int cyc);
    @(negedge clk);
    bus.start = 1'b1;
    wait_done(cyc);
  endtask

  task automatic check_box(string nm, int cyc, logic f,
                           int x0, int x1, int y0, int y1, int pc);
    checks++;
    if (cyc !== 34) begin
      errors++;
      $display("FAIL %s done_cycle: got %0d want 34", nm, cyc);
    end
    checks++;
    if (bus.found !== f) begin
      errors++;
      $display("FAIL %s found: got %b want %b", nm, bus.found, f);
    end
    checks++;
    if (bus.x_min !== 9'(x0) || bus.x_max !== 9'(x1) ||
        bus.y_min !== 9'(y0) || bus.y_max !== 9'(y1)) begin
      errors++;
      $display("FAIL %s box: got %0d %0d %0d %0d want %0d %0d %0d %0d",
               nm, bus.x_min, bus.x_max, bus.y_min, bus.y_max,
               x0, x1, y0, y1);
    end
    checks++;
    if (bus.rd_addr !== 17'd0) begin
      errors++;
      $display("FAIL %s rd_addr_done: got %0d want 0", nm, bus.rd_addr);
    end
`ifdef BW_BBOX_PIXEL_COUNT_EN
    checks++;
    if (bus.pixel_count !== 17'(pc)) begin
      errors++;
      $display("FAIL %s pixel_count: got %0d want %0d",
               nm, bus.pixel_count, pc);
    end
`else
    if (pc < 0) $display("negative pixel count %0d", pc);
`endif
  endtask

  task automatic do_ack(string nm);
    bus.ack   = 1'b1;
    bus.start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.ack = 1'b0;
    checks++;
    if (bus.done !== 1'b0) begin
      errors++;
      $display("FAIL %s ack_done: got %b want 0", nm, bus.done);
    end
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.ack   = 1'b0;
    clear_img();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b0 || bus.found !== 1'b0 || bus.rd_addr !== 17'd0 ||
        bus.x_min !== 9'd0 || bus.x_max !== 9'd0 ||
        bus.y_min !== 9'd0 || bus.y_max !== 9'd0) begin
      errors++;
      $display("FAIL reset: got done=%b found=%b addr=%0d box=%0d %0d %0d %0d want all 0",
               bus.done, bus.found, bus.rd_addr,
               bus.x_min, bus.x_max, bus.y_min, bus.y_max);
    end
    rst = 1'b0;
  endtask

  task automatic test_zero();
    int cyc;
    clear_img();
    run_scan(cyc);
    check_box("zero", cyc, 1'b0, 0, 0, 0, 0, 0);
    do_ack("zero");
  endtask

  task automatic test_single();
    int cyc;
    clear_img();
    mem[21] = 1'b1;
    run_scan(cyc);
    check_box("single", cyc, 1'b1, 5, 5, 2, 2, 1);
    do_ack("single");
  endtask

  task automatic test_two();
    int cyc;
    clear_img();
    mem[25] = 1'b1;
    mem[6]  = 1'b1;
    run_scan(cyc);
    check_box("two", cyc, 1'b1, 1, 6, 0, 3, 2);
    do_ack("two");
  endtask

  task automatic test_all_ones();
    int cyc;
    for (int i = 0; i < 32; i++) mem[i] = 1'b1;
    run_scan(cyc);
    check_box("ones", cyc, 1'b1, 0, 7, 0, 3, 32);
    do_ack("ones");
    clear_img();
    mem[0] = 1'b1;
    run_scan(cyc);
    check_box("rescan0", cyc, 1'b1, 0, 0, 0, 0, 1);
    do_ack("rescan0");
  endtask

  task automatic test_reset_mid();
    int cyc;
    clear_img();
    for (int i = 0; i < 32; i++) mem[i] = 1'b1;
    run_scan(cyc);
    do_ack("pre_mid");
    clear_img();
    mem[3] = 1'b1;
    @(negedge clk);
    bus.start = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.rd_addr !== 17'd9) begin
      errors++;
      $display("FAIL mid_addr: got %0d want 9", bus.rd_addr);
    end
    rst       = 1'b1;
    bus.start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (bus.done !== 1'b0 || bus.found !== 1'b0 || bus.rd_addr !== 17'd0 ||
        bus.x_max !== 9'd0 || bus.y_max !== 9'd0) begin
      errors++;
      $display("FAIL mid_reset: got done=%b found=%b addr=%0d xmax=%0d ymax=%0d want 0",
               bus.done, bus.found, bus.rd_addr, bus.x_max, bus.y_max);
    end
    mem[30] = 1'b1;
    run_scan(cyc);
    check_box("after_rst", cyc, 1'b1, 3, 6, 0, 3, 2);
    do_ack("after_rst");
  endtask

  task automatic test_hold();
    int cyc;
    int bad;
    clear_img();
    mem[10] = 1'b1;
    mem[13] = 1'b1;
    run_scan(cyc);
    check_box("hold", cyc, 1'b1, 2, 5, 1, 1, 2);
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      bus.start = i[0];
      mem[i % 32] = ~mem[i % 32];
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (bus.done !== 1'b1 || bus.x_min !== 9'd2 || bus.x_max !== 9'd5 ||
          bus.y_min !== 9'd1 || bus.y_max !== 9'd1 || bus.found !== 1'b1) begin
        errors++;
        bad++;
        if (bad < 4)
          $display("FAIL hold_stable[%0d]: got done=%b box=%0d %0d %0d %0d want 1 2 5 1 1",
                   i, bus.done, bus.x_min, bus.x_max, bus.y_min, bus.y_max);
      end
    end
    clear_img();
    mem[31] = 1'b1;
    bus.ack   = 1'b1;
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.ack = 1'b0;
    checks++;
    if (bus.done !== 1'b0) begin
      errors++;
      $display("FAIL ack_start_done: got %b want 0", bus.done);
    end
    wait_done(cyc);
    check_box("restart", cyc, 1'b1, 7, 7, 3, 3, 1);
    do_ack("restart");
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.ack   = 1'b0;
    test_reset();
    test_zero();
    test_single();
    test_two();
    test_all_ones();
    test_reset_mid();
    test_hold();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
